// File: rtl/router_bus_arbiter_pkg.sv
// Shared types and helpers for the RAM <-> accelerator FIFO router.
// The FSM state and the per-burst transfer direction are defined here.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  typedef enum logic {
    DIR_TO   = 1'b0,
    DIR_FROM = 1'b1
  } dir_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/router_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps.
// It returns both the one-hot grant and its index.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int NUM_CH = 3,
  localparam int CH_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    // k = NUM_CH wraps back to last_grant itself, so a lone requester can be re-granted.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_bus_arbiter.sv
// Moves words between the shared RAM port and NUM_CH accelerator FIFO pairs.
// Channels are served round-robin, one bounded burst per grant.
module router_bus_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 3,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        to_full,
  input  logic [NUM_CH-1:0]        to_empty,
  input  logic [NUM_CH-1:0]        from_full,
  input  logic [NUM_CH-1:0]        from_empty,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic [NUM_CH-1:0]        put_req,
  output logic [NUM_CH-1:0]        get_req,
  output logic                     ram_read_enable,
  output logic                     ram_write_enable,
  output logic [CH_W-1:0]          active_ch,
  output logic                     busy
);

  localparam int CNT_W = clog2(BURST_LEN + 1);

  // Strobe semantics: a pop/read strobe in REQ means the word is presented in the
  // following XFER cycle; push/write strobes are single-cycle and qualify their data.
  state_e              state;
  dir_e                dir;
  logic [CH_W-1:0]     last_grant;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   arb_grant_unused;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_valid;
  logic                cont;
  logic                unused_flags;

  assign unused_flags = ^{to_empty, from_full};
  assign eligible     = ch_enable & (~from_empty | ~to_full);
  assign count_next   = count + 1'b1;
  assign busy         = (state != IDLE);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req         (eligible),
    .last_grant  (last_grant),
    .grant       (arb_grant_unused),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Flags are re-sampled every REQ, after the previous push/pop has landed.
  assign cont = ch_enable[active_ch] &&
                ((dir == DIR_FROM) ? !from_empty[active_ch] : !to_full[active_ch]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= DIR_TO;
      last_grant <= CH_W'(NUM_CH - 1);
      active_ch  <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            active_ch  <= arb_idx;
            last_grant <= arb_idx;
            dir        <= from_empty[arb_idx] ? DIR_TO : DIR_FROM;
            count      <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          state <= cont ? XFER : IDLE;
        end
        XFER: begin
          count <= count_next;
          state <= (count_next == CNT_W'(BURST_LEN)) ? IDLE : REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    get_req          = '0;
    put_req          = '0;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ch_rdata         = '0;
    ram_wdata        = '0;
    case (state)
      REQ: begin
        if (cont) begin
          if (dir == DIR_FROM) get_req[active_ch] = 1'b1;
          else                 ram_read_enable    = 1'b1;
        end
      end
      XFER: begin
        if (dir == DIR_FROM) begin
          ram_write_enable = 1'b1;
          ram_wdata        = ch_wdata[active_ch*DATA_W +: DATA_W];
        end else begin
          put_req[active_ch] = 1'b1;
          ch_rdata           = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
